// File: rtl/placar_pkg.sv
// placar_pkg: shared state encoding, team indices and BCD limits for the score controller.
package placar_pkg;
    typedef enum logic [1:0] {IDLE, SOMA, ACK} estado_t;
    localparam logic TIME_A = 1'b0;
    localparam logic TIME_B = 1'b1;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [7:0] PLACAR_MAX = 8'h99;
endpackage

// File: rtl/placar_controlador_soma_bcd.sv
// soma_bcd: adds 0..3 points to a packed two-digit BCD score, saturating at 99.
module soma_bcd
    import placar_pkg::*;
(
    input  logic [7:0] placar_i,
    input  logic [1:0] pts_i,
    output logic [7:0] soma_o
);
    logic [4:0] uni;
    logic [3:0] uni_aj;
    logic       carry;
    logic [4:0] dez;
    always_comb begin
        uni    = {1'b0, placar_i[3:0]} + {3'b0, pts_i};
        carry  = uni > {1'b0, BCD_MAX};
        uni_aj = carry ? 4'(uni - 5'd10) : uni[3:0];
        dez    = {1'b0, placar_i[7:4]} + {4'b0, carry};
        soma_o = (dez > {1'b0, BCD_MAX}) ? PLACAR_MAX : {dez[3:0], uni_aj};
    end
endmodule

// File: rtl/placar_controlador.sv
// placar_controlador: round-robin score adder for two teams plus a two-slot display scan.
module placar_controlador
    import placar_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       zerar,
    input  logic       req_a,
    input  logic [1:0] pts_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [1:0] pts_b,
    output logic       ack_b,
    output logic [7:0] placar_a,
    output logic [7:0] placar_b,
    output logic [7:0] saida,
    output logic       sel,
    output logic       ocupado
);
    localparam int CW = $clog2(DIV);

    estado_t       state_q, state_d;
    logic          time_q, time_d;
    logic [1:0]    pts_q, pts_d;
    logic          ptr_q, ptr_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          grant_b;
    logic [7:0]    soma;

    soma_bcd u_soma (
        .placar_i(time_q == TIME_B ? b_q : a_q),
        .pts_i   (pts_q),
        .soma_o  (soma)
    );

    // B wins only when A is idle or A was the one served last
    assign grant_b = req_b && (!req_a || ptr_q == TIME_A);

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pts_d   = pts_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        if (zerar) begin
            state_d = IDLE;
            a_d     = 8'h00;
            b_d     = 8'h00;
        end else begin
            unique case (state_q)
                IDLE: if (req_a || req_b) begin
                    time_d  = grant_b ? TIME_B : TIME_A;
                    pts_d   = grant_b ? pts_b : pts_a;
                    ptr_d   = grant_b ? TIME_B : TIME_A;
                    state_d = SOMA;
                end
                SOMA: begin
                    a_d     = (time_q == TIME_A) ? soma : a_q;
                    b_d     = (time_q == TIME_B) ? soma : b_q;
                    state_d = ACK;
                end
                ACK:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        cnt_d = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        sel_d = (cnt_q == CW'(DIV - 1)) ? !sel_q : sel_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            time_q  <= TIME_A;
            pts_q   <= 2'd0;
            ptr_q   <= TIME_B;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            pts_q   <= pts_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    assign ack_a    = (state_q == ACK) && (time_q == TIME_A);
    assign ack_b    = (state_q == ACK) && (time_q == TIME_B);
    assign ocupado  = state_q != IDLE;
    assign placar_a = a_q;
    assign placar_b = b_q;
    assign sel      = sel_q;
    assign saida    = sel_q ? b_q : a_q;
endmodule

// File: tb/tb_placar_controlador.sv
// tb_placar_controlador: directed stimulus with a queue-based ack scoreboard.
module tb_placar_controlador;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       zerar = 1'b0;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [1:0] pts_a = 2'd0, pts_b = 2'd0;
    logic       ack_a, ack_b, sel, ocupado;
    logic [7:0] placar_a, placar_b, saida;

    typedef struct packed {
        logic       team;
        logic [7:0] score;
    } exp_t;
    exp_t q[$];
    int checks = 0;
    int errors = 0;

    placar_controlador #(.DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .zerar(zerar),
        .req_a(req_a), .pts_a(pts_a), .ack_a(ack_a),
        .req_b(req_b), .pts_b(pts_b), .ack_b(ack_b),
        .placar_a(placar_a), .placar_b(placar_b),
        .saida(saida), .sel(sel), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int d);
        return 8'((d / 10) * 16 + d % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every ack pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (ack_a || ack_b) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack_a=%0b ack_b=%0b expected none", ack_a, ack_b);
            end else begin
                e = q.pop_front();
                if (ack_a && ack_b) begin
                    errors++;
                    $display("FAIL dual_ack: got both acks expected one");
                end else if (ack_b != e.team || (ack_b ? placar_b : placar_a) != e.score) begin
                    errors++;
                    $display("FAIL ack_score: got team %0d score %0h expected team %0d score %0h",
                             ack_b, ack_b ? placar_b : placar_a, e.team, e.score);
                end
            end
        end
    end

    task automatic do_req(input logic team, input logic [1:0] pts, input logic [7:0] exp);
        logic got = 1'b0;
        q.push_back('{team, exp});
        if (team) begin req_b = 1'b1; pts_b = pts; end
        else begin req_a = 1'b1; pts_a = pts; end
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = team ? ack_b : ack_a;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack for team %0d", team);
            void'(q.pop_back());
        end else begin
            @(negedge clk);
            chk("ack_width", {31'b0, ack_a | ack_b}, 32'd0);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int d;
        int seen;
        logic s0;
        logic prev;
        logic changed;
        reset_dut();
        chk("rst_placar_a", placar_a, 8'h00);
        chk("rst_placar_b", placar_b, 8'h00);
        chk("rst_saida", saida, 8'h00);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_acks", {ack_a, ack_b}, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("first_toggle", sel, (i == 4));
        end

        do_req(1'b0, 2'd3, 8'h03);
        chk("single_a", placar_a, 8'h03);
        chk("single_b_untouched", placar_b, 8'h00);
        do_req(1'b0, 2'd3, 8'h06);
        do_req(1'b0, 2'd2, 8'h08);
        do_req(1'b0, 2'd3, 8'h11);
        d = 11;
        for (int i = 0; i < 29; i++) begin
            d += 3;
            do_req(1'b0, 2'd3, bcd(d));
        end
        chk("reach_98", placar_a, 8'h98);
        do_req(1'b0, 2'd2, 8'h99);
        do_req(1'b0, 2'd1, 8'h99);
        do_req(1'b0, 2'd0, 8'h99);
        chk("saturated", placar_a, 8'h99);

        zerar = 1'b1;
        @(negedge clk);
        zerar = 1'b0;
        chk("zerar_a", placar_a, 8'h00);
        for (int i = 0; i < 15; i++) do_req(1'b1, 2'd3, bcd(3 * (i + 1)));
        chk("b_45", placar_b, 8'h45);

        req_b = 1'b1;
        pts_b = 2'd2;
        @(negedge clk);
        chk("busy_soma", ocupado, 1);
        zerar = 1'b1;
        @(negedge clk);
        zerar = 1'b0;
        req_b = 1'b0;
        chk("zerar_mid_b", placar_b, 8'h00);
        chk("zerar_idle", ocupado, 0);
        repeat (4) @(negedge clk);
        do_req(1'b1, 2'd2, 8'h02);

        zerar = 1'b1;
        @(negedge clk);
        zerar = 1'b0;
        for (int i = 0; i < 4; i++) do_req(1'b0, 2'd3, bcd(3 * (i + 1)));
        for (int i = 0; i < 11; i++) do_req(1'b1, 2'd3, bcd(3 * (i + 1)));
        do_req(1'b1, 2'd1, 8'h34);
        prev = sel;
        changed = 1'b0;
        for (int i = 0; i < 20 && !changed; i++) begin
            @(negedge clk);
            changed = sel != prev;
        end
        chk("scan_toggle_seen", changed, 1);
        s0 = sel;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk("scan_sel", sel, (i < 4) ? s0 : !s0);
            chk("scan_saida", saida, ((i < 4) ? s0 : !s0) ? 8'h34 : 8'h12);
        end

        q.push_back('{1'b0, 8'h13});
        req_a = 1'b1;
        pts_a = 2'd1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (ack_a) seen = 1;
        end
        chk("ack_before_reset", seen, 1);
        rst_n = 1'b0;
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ack_drop", {ack_a, ack_b}, 0);
        chk("rst_mid_a", placar_a, 8'h00);
        chk("rst_mid_b", placar_b, 8'h00);
        chk("rst_mid_sel", sel, 0);
        chk("rst_mid_ocupado", ocupado, 0);

        q.push_back('{1'b0, 8'h01});
        q.push_back('{1'b1, 8'h01});
        q.push_back('{1'b0, 8'h02});
        q.push_back('{1'b1, 8'h02});
        req_a = 1'b1;
        req_b = 1'b1;
        pts_a = 2'd1;
        pts_b = 2'd1;
        seen = 0;
        for (int i = 0; i < 40 && seen < 4; i++) begin
            @(negedge clk);
            if (ack_a || ack_b) seen++;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        chk("tie_acks", seen, 4);
        repeat (4) @(negedge clk);
        chk("tie_a", placar_a, 8'h02);
        chk("tie_b", placar_b, 8'h02);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
